square_voice_mixer: RTL and testbench

- Upstream sample source for the I2S serializer.
- Once per sample period, keyed off the shared `master_count_in` from `master_counter`, it time-multiplexes NUM_VOICES square-wave voices. Each voice has a phase accumulator and a volume.
- The voices are summed, the sum is saturated to 16-bit signed, and the result is presented as `data_out` with a one-cycle `data_valid_out` strobe that feeds the serializer's `data_in`/`data_valid_in`.
- Voice settings are written through a simple register-write port.

---
 rtl/square_voice_mixer.sv | 161 ++++++++++++++++
 tb/tb_square_voice_mixer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_voice_mixer.sv
// rtl/square_voice_mixer.sv - time-multiplexed square-wave voice mixer feeding the I2S serializer.
// Optional noise voice on the last voice slot: define NOISE_VOICE_EN.
module square_voice_mixer #(
    parameter int NUM_VOICES         = 4,
    parameter int MASTER_COUNT_WIDTH = 10,
    parameter int START_COUNT        = 0,
    parameter int AMP_SHIFT          = 9
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic [MASTER_COUNT_WIDTH-1:0] master_count_in,
    input  logic                          reg_we_in,
    input  logic [3:0]                    reg_addr_in,
    input  logic [15:0]                   reg_data_in,
    output logic [15:0]                   data_out,
    output logic                          data_valid_out,
    output logic                          busy_out
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    // Headroom for NUM_VOICES (<= 8) full-scale voices plus sign, never narrower than the clamp limits.
    localparam int ACC_W = (AMP_SHIFT + 9 > 17) ? AMP_SHIFT + 9 : 17;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [MASTER_COUNT_WIDTH-1:0] START_MATCH = MASTER_COUNT_WIDTH'(START_COUNT);
    localparam logic signed [ACC_W-1:0] POS_LIMIT = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] NEG_LIMIT = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  amp_d;
    logic [15:0]              phase_next_d;
    logic                     sign_pos_d;
    logic [15:0]              sat_d;
    logic [15:0]              data_q;
    logic                     valid_q;
    logic                     busy_q;

    logic [15:0] shadow_freq_q [NUM_VOICES];
    logic [3:0]  shadow_vol_q  [NUM_VOICES];
    logic [15:0] active_freq_q [NUM_VOICES];
    logic [3:0]  active_vol_q  [NUM_VOICES];
    logic [15:0] phase_q       [NUM_VOICES];

`ifdef NOISE_VOICE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                shadow_freq_q[v] <= '0;
                shadow_vol_q[v]  <= '0;
            end
        end else if (reg_we_in) begin
            // Out-of-range voice indices simply match no slot.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (reg_addr_in[3:1] == 3'(v)) begin
                    if (reg_addr_in[0]) begin
                        shadow_vol_q[v] <= reg_data_in[3:0];
                    end else begin
                        shadow_freq_q[v] <= reg_data_in;
                    end
                end
            end
        end
    end

    always_comb begin
        phase_next_d = phase_q[idx_q] + active_freq_q[idx_q];
        sign_pos_d   = phase_q[idx_q][15];
`ifdef NOISE_VOICE_EN
        if (idx_q == LAST_IDX) begin
            sign_pos_d = lfsr_q[0];
        end
`endif
        amp_d = ACC_W'(active_vol_q[idx_q]) << AMP_SHIFT;
        acc_d = sign_pos_d ? (acc_q + amp_d) : (acc_q - amp_d);
        if (acc_q > POS_LIMIT) begin
            sat_d = 16'h7FFF;
        end else if (acc_q < NEG_LIMIT) begin
            sat_d = 16'h8000;
        end else begin
            sat_d = acc_q[15:0];
        end
    end

`ifdef NOISE_VOICE_EN
    // A wrapped 16-bit sum is smaller than its addend exactly when the add carried out.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ACCUM && idx_q == LAST_IDX && phase_next_d < phase_q[idx_q]) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                active_freq_q[v] <= '0;
                active_vol_q[v]  <= '0;
                phase_q[v]       <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (master_count_in == START_MATCH) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            active_freq_q[v] <= shadow_freq_q[v];
                            active_vol_q[v]  <= shadow_vol_q[v];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q          <= acc_d;
                    phase_q[idx_q] <= phase_next_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= SAT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SAT: begin
                    data_q  <= sat_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_square_voice_mixer.sv
// tb/tb_square_voice_mixer.sv - randomized self-checking bench for square_voice_mixer.
module tb_square_voice_mixer;
    localparam int NV  = 4;
    localparam int MCW = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [MCW-1:0] mc;
    logic           we_a, we_b;
    logic [3:0]     addr;
    logic [15:0]    wdata;
    logic [15:0]    dout_a, dout_b;
    logic           valid_a, valid_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cyc = 0;

    // model state: [0] = default instance, [1] = AMP_SHIFT 11 instance
    int m_freq  [2][NV];
    int m_vol   [2][NV];
    int m_phase [2][NV];
    int m_lfsr  [2];
    int exp_data[2];

    always #5 clk = ~clk;

    square_voice_mixer u_a (
        .clk_in(clk), .reset_in(reset), .master_count_in(mc),
        .reg_we_in(we_a), .reg_addr_in(addr), .reg_data_in(wdata),
        .data_out(dout_a), .data_valid_out(valid_a), .busy_out(busy_a)
    );

    square_voice_mixer #(.AMP_SHIFT(11)) u_b (
        .clk_in(clk), .reset_in(reset), .master_count_in(mc),
        .reg_we_in(we_b), .reg_addr_in(addr), .reg_data_in(wdata),
        .data_out(dout_b), .data_valid_out(valid_b), .busy_out(busy_b)
    );

    initial begin
        mc = '0;
        forever begin
            @(negedge clk);
            mc = mc + 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < NV; v++) begin
                m_freq[d][v]  = 0;
                m_vol[d][v]   = 0;
                m_phase[d][v] = 0;
            end
            m_lfsr[d]   = 16'hACE1;
            exp_data[d] = 0;
        end
    endtask

    task automatic model_write(input int d, input int a, input int data);
        int v;
        v = a / 2;
        if (v < NV) begin
            if (a % 2 == 1) m_vol[d][v] = data % 16;
            else            m_freq[d][v] = data;
        end
    endtask

    // Sample value of one frame from the voice settings captured at frame start.
    task automatic predict();
        for (int d = 0; d < 2; d++) begin
            int shift, sum, amp, nxt, bitv;
            bit pos, carry;
            shift = (d == 1) ? 11 : 9;
            sum = 0;
            for (int v = 0; v < NV; v++) begin
                amp   = m_vol[d][v] * (1 << shift);
                pos   = (m_phase[d][v] >= 32768);
                nxt   = m_phase[d][v] + m_freq[d][v];
                carry = (nxt >= 65536);
                m_phase[d][v] = nxt % 65536;
`ifdef NOISE_VOICE_EN
                if (v == NV - 1) begin
                    pos = (m_lfsr[d] % 2 == 1);
                    if (carry) begin
                        bitv = (m_lfsr[d] ^ (m_lfsr[d] >> 2) ^ (m_lfsr[d] >> 3) ^ (m_lfsr[d] >> 5)) & 1;
                        m_lfsr[d] = (m_lfsr[d] >> 1) | (bitv << 15);
                    end
                end
`endif
                sum += pos ? amp : -amp;
            end
            if (sum > 32767) sum = 32767;
            if (sum < -32768) sum = -32768;
            exp_data[d] = sum & 16'hFFFF;
        end
    endtask

    task automatic do_write(input bit sa, input bit sb, input int a, input int data);
        we_a = sa;
        we_b = sb;
        addr = 4'(a);
        wdata = 16'(data);
        if (sa) model_write(0, a, data);
        if (sb) model_write(1, a, data);
        tick();
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Leaves the bench just ahead of the edge where master_count matches START_COUNT.
    task automatic wait_frame();
        int n;
        n = 0;
        while (mc != 0 && n < 2100) begin
            tick();
            n++;
        end
        checks++;
        if (mc != 0) begin
            errors++;
            $display("FAIL wait_frame: master count %0d never reached start, required 0", mc);
        end
    endtask

    task automatic run_frame(input string name);
        bit exp_v, exp_b;
        for (int k = 0; k <= NV + 2; k++) begin
            tick();
            we_a = 1'b0;
            we_b = 1'b0;
            exp_v = (k == NV + 1);
            exp_b = (k <= NV);
            checks++;
            if (valid_a !== exp_v) begin
                errors++;
                $display("FAIL %s valid k=%0d: got %b required %b", name, k, valid_a, exp_v);
            end
            checks++;
            if (busy_a !== exp_b) begin
                errors++;
                $display("FAIL %s busy k=%0d: got %b required %b", name, k, busy_a, exp_b);
            end
            if (k >= NV + 1) begin
                if (k == NV + 1) valid_cyc = cyc;
                checks++;
                if (dout_a !== 16'(exp_data[0])) begin
                    errors++;
                    $display("FAIL %s data_a k=%0d: got %h required %h", name, k, dout_a, 16'(exp_data[0]));
                end
                checks++;
                if (dout_b !== 16'(exp_data[1]) || valid_b !== exp_v) begin
                    errors++;
                    $display("FAIL %s data_b k=%0d: got %h/%b required %h/%b", name, k, dout_b, valid_b,
                             16'(exp_data[1]), exp_v);
                end
            end
        end
    endtask

    task automatic frame(input string name);
        wait_frame();
        predict();
        run_frame(name);
    endtask

    task automatic test_reset();
        we_a = 1'b0; we_b = 1'b0; addr = '0; wdata = '0;
        apply_reset();
        checks++;
        if (dout_a !== 16'h0000 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b required 0000/0/0", dout_a, valid_a, busy_a);
        end
    endtask

    task automatic test_silent_frames();
        int prev;
        frame("silent0");
        prev = valid_cyc;
        for (int i = 1; i < 3; i++) begin
            frame("silent");
            checks++;
            if (valid_cyc - prev != 1024) begin
                errors++;
                $display("FAIL silent_spacing: got %0d cycles required 1024", valid_cyc - prev);
            end
            prev = valid_cyc;
        end
    endtask

    task automatic test_square_voice0();
        apply_reset();
        do_write(1, 1, 0, 16'h8000);
        do_write(1, 1, 1, 15);
        for (int i = 0; i < 4; i++) begin
            frame("square");
            checks++;
            if (dout_a !== ((i % 2 == 0) ? 16'hE200 : 16'h1E00)) begin
                errors++;
                $display("FAIL square_const frame %0d: got %h", i, dout_a);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int v = 0; v < NV; v++) do_write(1, 1, 2 * v + 1, 15);
        frame("sat_neg");
        checks++;
        if (dout_b !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg_const: got %h required 8000", dout_b);
        end
        for (int v = 0; v < NV; v++) do_write(1, 1, 2 * v, 16'h8000);
        frame("sat_hold");
        frame("sat_pos");
        checks++;
        if (dout_b !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos_const: got %h required 7FFF", dout_b);
        end
    endtask

    task automatic test_edge_write();
        apply_reset();
        do_write(1, 1, 3, 4);
        wait_frame();
        predict();
        we_a = 1'b1; we_b = 1'b1; addr = 4'd3; wdata = 16'd12;
        model_write(0, 3, 12);
        model_write(1, 3, 12);
        run_frame("edge_old");
        checks++;
        if (dout_a !== 16'hF800) begin
            errors++;
            $display("FAIL edge_old_const: got %h required F800", dout_a);
        end
        frame("edge_new");
        checks++;
        if (dout_a !== 16'hE800) begin
            errors++;
            $display("FAIL edge_new_const: got %h required E800", dout_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_write(1, 1, 0, 16'h8000);
        do_write(1, 1, 1, 15);
        wait_frame();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int k = 0; k <= NV + 2; k++) begin
            tick();
            checks++;
            if (valid_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 16'h0000) begin
                errors++;
                $display("FAIL abort k=%0d: got %b/%b/%h required 0/0/0000", k, valid_a, busy_a, dout_a);
            end
        end
        do_write(1, 1, 0, 16'h8000);
        do_write(1, 1, 1, 15);
        frame("after_abort");
        checks++;
        if (dout_a !== 16'hE200) begin
            errors++;
            $display("FAIL after_abort_const: got %h required E200", dout_a);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int w = 0; w < n; w++) begin
                do_write(1'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 65535));
            end
            frame("random");
        end
    endtask

`ifdef NOISE_VOICE_EN
    task automatic test_noise();
        apply_reset();
        do_write(1, 1, 2 * (NV - 1), 16'hFFFF);
        do_write(1, 1, 2 * (NV - 1) + 1, 15);
        for (int i = 0; i < 6; i++) frame("noise");
        do_write(1, 1, 2 * (NV - 1), 0);
        for (int i = 0; i < 3; i++) frame("noise_stall");
    endtask
`endif

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_silent_frames();
        test_square_voice0();
        test_saturation();
        test_edge_write();
        test_reset_mid_frame();
        test_random();
`ifdef NOISE_VOICE_EN
        test_noise();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
